// File: rtl/gauss_frame_ctrl.sv
// gauss_frame_ctrl: frame sequencer that feeds a 3x3 Gaussian filter core.
// Latency: 10 + L + 1 cycles per interior window (L = filter done latency).
// Backpressure: holds flt_en_o until flt_done_i or a FLT_TIMEOUT-cycle timeout.
//
// Ports: clk_i_c/rst_i_c (sync active-high reset), start_i/busy_o/frame_done_o/
//   err_o framing, rd_en_o/rd_addr_o/rd_data_i image RAM read port (1-cycle
//   read latency), win_o 3x3 window (slot k = 3*row+col), flt_en_o/flt_data_i/
//   flt_done_i filter handshake, wr_en_o/wr_addr_o/wr_data_o output RAM port.
// Optional macro GAUSS_CTRL_BORDER_COPY_EN: copy border pixels unchanged
//   into the output memory after the interior pass.
module gauss_frame_ctrl #(
  parameter int IMG_W       = 16,
  parameter int IMG_H       = 16,
  parameter int AW          = 8,
  parameter int FLT_TIMEOUT = 64
) (
  input  logic          clk_i_c,
  input  logic          rst_i_c,
  input  logic          start_i,
  output logic          busy_o,
  output logic          frame_done_o,
  output logic          err_o,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic [7:0]    rd_data_i,
  output logic [71:0]   win_o,
  output logic          flt_en_o,
  input  logic [7:0]    flt_data_i,
  input  logic          flt_done_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [7:0]    wr_data_o
);

  localparam int TW = $clog2(FLT_TIMEOUT) + 1;
  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] W_A  = AW'(IMG_W);
  localparam logic [AW-1:0] C_LAST = AW'(IMG_W - 2);
  localparam logic [AW-1:0] R_LAST = AW'(IMG_H - 2);
  localparam logic [TW-1:0] TMO_LAST = TW'(FLT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, RUN, WRITE, FIN
`ifdef GAUSS_CTRL_BORDER_COPY_EN
    , BORDER
`endif
  } state_t;

  // State entered after the last interior window.
`ifdef GAUSS_CTRL_BORDER_COPY_EN
  localparam state_t POST_ST = BORDER;
`else
  localparam state_t POST_ST = FIN;
`endif

  state_t        state_q, state_d;
  logic [AW-1:0] r_q, c_q;
  logic [3:0]    k_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    res_q;
  logic [71:0]   win_q;
  logic          err_q;

  logic [AW-1:0] ro, co, fetch_addr;
  logic          last_win, tmo_hit, adv;

`ifdef GAUSS_CTRL_BORDER_COPY_EN
  localparam logic [AW-1:0] W_M1 = AW'(IMG_W - 1);
  localparam logic [AW-1:0] H_M1 = AW'(IMG_H - 1);
  logic [AW-1:0] br_q, bc_q, bwa_q;
  logic          bdone_q, bpend_q;
  logic          b_edge_row;
  assign b_edge_row = (br_q == '0) || (br_q == H_M1);
`endif

  assign last_win = (r_q == R_LAST) && (c_q == C_LAST);
  assign adv      = (state_q == WRITE) || tmo_hit;
  assign win_o    = win_q;
  assign err_o    = err_q;

  // Window offset for fetch step k: row = k/3, col = k%3.
  always_comb begin
    if (k_q < 4'd3)      ro = '0;
    else if (k_q < 4'd6) ro = ONE;
    else                 ro = AW'(2);
    co = AW'(k_q) - AW'(3) * ro;
    fetch_addr = (r_q - ONE + ro) * W_A + (c_q - ONE + co);
  end

  always_comb begin
    state_d      = state_q;
    busy_o       = 1'b0;
    frame_done_o = 1'b0;
    rd_en_o      = 1'b0;
    rd_addr_o    = '0;
    flt_en_o     = 1'b0;
    wr_en_o      = 1'b0;
    wr_addr_o    = '0;
    wr_data_o    = '0;
    tmo_hit      = 1'b0;
    case (state_q)
      IDLE: if (start_i) state_d = FETCH;
      FETCH: begin
        busy_o = 1'b1;
        if (k_q < 4'd9) begin
          rd_en_o   = 1'b1;
          rd_addr_o = fetch_addr;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        busy_o   = 1'b1;
        flt_en_o = 1'b1;
        if (flt_done_i) begin
          state_d = WRITE;
        end else if (tmo_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = last_win ? POST_ST : FETCH;
        end
      end
      WRITE: begin
        busy_o    = 1'b1;
        wr_en_o   = 1'b1;
        wr_addr_o = r_q * W_A + c_q;
        wr_data_o = res_q;
        state_d   = last_win ? POST_ST : FETCH;
      end
      FIN: begin
        frame_done_o = 1'b1;
        state_d      = IDLE;
      end
`ifdef GAUSS_CTRL_BORDER_COPY_EN
      // Read stage and write stage overlap: data read last cycle is written now.
      BORDER: begin
        busy_o = 1'b1;
        if (!bdone_q) begin
          rd_en_o   = 1'b1;
          rd_addr_o = br_q * W_A + bc_q;
        end
        if (bpend_q) begin
          wr_en_o   = 1'b1;
          wr_addr_o = bwa_q;
          wr_data_o = rd_data_i;
        end
        if (bdone_q) state_d = FIN;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i_c) begin
    if (rst_i_c) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      tmo_q   <= '0;
      res_q   <= '0;
      win_q   <= '0;
      err_q   <= 1'b0;
`ifdef GAUSS_CTRL_BORDER_COPY_EN
      br_q    <= '0;
      bc_q    <= '0;
      bwa_q   <= '0;
      bdone_q <= 1'b0;
      bpend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start_i) begin
          r_q   <= ONE;
          c_q   <= ONE;
          k_q   <= '0;
          err_q <= 1'b0;
        end
        FETCH: begin
          // Read data lags the strobe by one cycle, so step k+1 captures slot k.
          for (int i = 0; i < 9; i++)
            if (k_q == 4'(i + 1)) win_q[8*i +: 8] <= rd_data_i;
          k_q   <= k_q + 4'd1;
          tmo_q <= '0;
        end
        RUN: begin
          tmo_q <= tmo_q + TW'(1);
          if (flt_done_i) res_q <= flt_data_i;
          else if (tmo_hit) err_q <= 1'b1;
        end
`ifdef GAUSS_CTRL_BORDER_COPY_EN
        BORDER: begin
          bpend_q <= !bdone_q;
          bwa_q   <= br_q * W_A + bc_q;
          if (!bdone_q) begin
            if (br_q == H_M1 && bc_q == W_M1) bdone_q <= 1'b1;
            // Edge rows walk every column; middle rows jump col 0 -> last col.
            if (b_edge_row ? (bc_q == W_M1) : (bc_q != '0)) begin
              bc_q <= '0;
              br_q <= br_q + ONE;
            end else begin
              bc_q <= b_edge_row ? bc_q + ONE : W_M1;
            end
          end
        end
`endif
        default: ;
      endcase
      if (adv) begin
        k_q <= '0;
        if (c_q == C_LAST) begin
          c_q <= ONE;
          r_q <= r_q + ONE;
        end else begin
          c_q <= c_q + ONE;
        end
`ifdef GAUSS_CTRL_BORDER_COPY_EN
        if (last_win) begin
          br_q    <= '0;
          bc_q    <= '0;
          bdone_q <= 1'b0;
          bpend_q <= 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_gauss_frame_ctrl.sv
module tb_gauss_frame_ctrl;
  localparam int W = 4, H = 4, AW = 8, TMO = 64, LAT = 8;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic          busy, frame_done, err, rd_en, flt_en, flt_done, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [7:0]    rd_data = '0, flt_data, wr_data;
  logic [71:0]   win;

  always #5 clk = ~clk;

  gauss_frame_ctrl #(.IMG_W(W), .IMG_H(H), .AW(AW), .FLT_TIMEOUT(TMO)) dut (
    .clk_i_c(clk), .rst_i_c(rst), .start_i(start), .busy_o(busy),
    .frame_done_o(frame_done), .err_o(err), .rd_en_o(rd_en), .rd_addr_o(rd_addr),
    .rd_data_i(rd_data), .win_o(win), .flt_en_o(flt_en), .flt_data_i(flt_data),
    .flt_done_i(flt_done), .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data)
  );

  // Image memory: strobe sampled mid-cycle, data returned on the next edge.
  logic [7:0]    img [0:255];
  logic          rd_pend = 1'b0;
  logic [AW-1:0] rd_a = '0;
  always @(negedge clk) begin
    rd_pend <= rd_en;
    rd_a    <= rd_addr;
  end
  always @(posedge clk) if (rd_pend) rd_data <= img[rd_a];

  // Filter model: result = window centre, done after LAT enabled cycles.
  int   ecnt = 0;
  bit   never = 1'b0;
  logic spur = 1'b0;
  always @(negedge clk) ecnt <= flt_en ? ecnt + 1 : 0;
  assign flt_done = (flt_en && ecnt == LAT && !never) || spur;
  assign flt_data = win[39:32];

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic note_fail(input string nm, input int act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0d required=none", nm, act);
  endtask

  // Scoreboard queues.
  logic [AW-1:0] rd_q[$];
  logic [15:0]   wr_q[$];
  logic [71:0]   win_q[$];
  int            len_q[$];
  bit            quiet = 1'b0;
  logic          en_prev = 1'b0;
  int            en_len = 0;

  always @(negedge clk) begin
    if (!rst && !quiet) begin
      if (rd_en) begin
        if (rd_q.size() == 0) note_fail("rd_extra", int'(rd_addr));
        else chk("rd_addr", rd_addr, rd_q.pop_front());
      end
      if (flt_en && !en_prev) begin
        if (win_q.size() == 0) note_fail("win_extra", 0);
        else chk("win", win, win_q.pop_front());
      end
      if (!flt_en && en_prev) begin
        if (len_q.size() == 0) note_fail("en_len_extra", en_len);
        else chk("en_len", en_len, len_q.pop_front());
      end
    end
    if (!rst && wr_en) begin
      if (wr_q.size() == 0) note_fail("wr_extra", int'(wr_addr));
      else chk("wr", {wr_addr, wr_data}, wr_q.pop_front());
    end
    en_prev <= flt_en;
    en_len  <= flt_en ? en_len + 1 : 0;
  end

  // Push expected reads, windows, enable lengths and writes for one frame.
  task automatic push_frame(input bit tmo_first);
    logic [71:0] w;
    int a, idx;
    idx = 0;
    for (int r = 1; r <= H - 2; r++)
      for (int c = 1; c <= W - 2; c++) begin
        for (int k = 0; k < 9; k++) begin
          a = (r - 1 + k / 3) * W + (c - 1 + k % 3);
          rd_q.push_back(AW'(a));
          w[8*k +: 8] = img[a];
        end
        win_q.push_back(w);
        if (tmo_first && idx == 0) len_q.push_back(TMO);
        else begin
          len_q.push_back(LAT);
          wr_q.push_back({AW'(r * W + c), img[r * W + c]});
        end
        idx++;
      end
`ifdef GAUSS_CTRL_BORDER_COPY_EN
    for (int b = 0; b < W * H; b++)
      if (b / W == 0 || b / W == H - 1 || b % W == 0 || b % W == W - 1) begin
        rd_q.push_back(AW'(b));
        wr_q.push_back({AW'(b), img[b]});
      end
`endif
  endtask

  task automatic run_frame(input string tag, input bit tmo_first, input bit poke);
    int cyc, pulses;
    bit seen, poked, spurred;
    cyc = 0; pulses = 0; seen = 0; poked = 0; spurred = 0;
    never = tmo_first;
    push_frame(tmo_first);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, "_busy_start"}, busy, 1'b1);
    chk({tag, "_err_clr"}, err, 1'b0);
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (start) start = 1'b0;
      else if (poke && !poked && flt_en) begin start = 1'b1; poked = 1; end
      if (spur) spur = 1'b0;
      else if (poke && !spurred && rd_en) begin spur = 1'b1; spurred = 1; end
      if (tmo_first && !flt_en && en_prev) never = 1'b0;
      if (frame_done) begin
        seen = 1;
        pulses++;
        chk({tag, "_busy_at_done"}, busy, 1'b0);
      end
    end
    if (!seen) note_fail({tag, "_frame_timeout"}, cyc);
    repeat (5) begin
      @(negedge clk);
      if (frame_done) pulses++;
    end
    chk({tag, "_done_pulses"}, pulses, 1);
    chk({tag, "_err_after"}, err, tmo_first);
    chk({tag, "_wr_left"}, wr_q.size(), 0);
    chk({tag, "_rd_left"}, rd_q.size(), 0);
    chk({tag, "_win_left"}, win_q.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, frame_done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_rd"}, {rd_en, rd_addr}, '0);
    chk({tag, "_win"}, win, '0);
    chk({tag, "_flt_en"}, flt_en, 1'b0);
    chk({tag, "_wr"}, {wr_en, wr_addr, wr_data}, '0);
  endtask

  initial begin
    int cyc, nwr;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 256; i++) img[i] = 8'd100;
    run_frame("const", 0, 0);

    for (int i = 0; i < 256; i++) img[i] = 8'(i);
    run_frame("ramp", 0, 0);

    for (int i = 0; i < 256; i++) img[i] = 8'(i) ^ 8'h5A;
    run_frame("tmo", 1, 0);
    repeat (10) @(negedge clk);
    chk("tmo_err_sticky", err, 1'b1);

    for (int i = 0; i < 256; i++) img[i] = 8'(3 * i + 7);
    run_frame("poke", 0, 1);

    // Abort mid-frame with a long reset; nothing may be written afterwards.
    quiet = 1'b1;
    never = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!flt_en && cyc < 100) begin @(negedge clk); cyc++; end
    if (!flt_en) note_fail("abort_no_run", cyc);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    never = 1'b0;
    nwr = 0;
    repeat (200) begin
      @(negedge clk);
      if (wr_en) nwr++;
    end
    chk("abort_no_wr", nwr, 0);
    chk("abort_idle", busy, 1'b0);
    quiet = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
